// File: rtl/fifo_wm_pkg.sv
// fifo_wm_pkg: shared defaults, count-width helper and status bundle for fifo_wm
package fifo_wm_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic empty;
    logic full;
    logic thr_trig;
    logic overflow;
    logic underflow;
    logic ovf_sticky;
    logic udf_sticky;
  } fifo_status_t;
endpackage

// File: rtl/fifo_wm_mem.sv
// fifo_wm_mem: FIFO storage, registered read port or fall-through when FIFO_WM_FWFT_EN is defined
module fifo_wm_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
`ifdef FIFO_WM_FWFT_EN
  logic [DATA_W-1:0] hold;
  // re means "head valid": hold remembers the last presented head for the empty case
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold <= '0;
    else if (re) hold <= mem[raddr];
  assign rdata = re ? mem[raddr] : hold;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
`endif
endmodule

// File: rtl/fifo_wm.sv
// fifo_wm: parametrised FIFO with hysteresis threshold, sticky errors and flush; FIFO_WM_FWFT_EN selects fall-through read
module fifo_wm import fifo_wm_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  input  logic              clr,
  input  logic [CNT_W-1:0]  trig_level,
  input  logic [CNT_W-1:0]  low_level,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              thr_trig,
  output logic              overflow,
  output logic              underflow,
  output logic              ovf_sticky,
  output logic              udf_sticky,
  input  logic              err_clr
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt_n, eff_low;
  logic wr_acc, rd_acc, ovf_n, udf_n, thr_n, rd_en;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  always_comb begin
    wr_acc = wr & (!full | rd) & !clr;
    rd_acc = rd & !empty & !clr;
    ovf_n = wr & full & !rd & !clr;
    udf_n = rd & empty & !wr & !clr;
    eff_low = low_level < trig_level ? low_level : trig_level;
    cnt_n = clr ? '0 : count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    // set at/above trig_level, hold inside the hysteresis band, clear below it
    thr_n = !clr & (trig_level != '0) & ((cnt_n >= trig_level) | ((cnt_n >= eff_low) & thr_trig));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      thr_trig <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      rd_ptr <= clr ? '0 : rd_acc ? inc(rd_ptr) : rd_ptr;
      wr_ptr <= clr ? '0 : wr_acc ? inc(wr_ptr) : wr_ptr;
      count <= cnt_n;
      empty <= cnt_n == '0;
      full <= cnt_n == CNT_W'(DEPTH);
      thr_trig <= thr_n;
      overflow <= ovf_n;
      underflow <= udf_n;
      ovf_sticky <= ovf_n | (ovf_sticky & !err_clr);
      udf_sticky <= udf_n | (udf_sticky & !err_clr);
    end
`ifdef FIFO_WM_FWFT_EN
  assign rd_en = !empty;
`else
  assign rd_en = rd_acc;
`endif
  fifo_wm_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr_acc),
    .waddr(wr_ptr),
    .wdata(din),
    .re(rd_en),
    .raddr(rd_ptr),
    .rdata(dout)
  );
endmodule
